rv_muldiv: RTL
==============

# rv_muldiv

Iterative multiply/divide unit implementing the RV32M operations, parametrised in data width, for use beside the single-cycle `alu` in the execute stage. It accepts one operation at a time over a valid/ready handshake, computes in one bit per clock, and holds the result until the consumer takes it. Divide-by-zero and signed-overflow cases complete on a fast path. A synchronous kill supports pipeline flush.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width; must be at least 8 and even.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  unit idle, so a request can be accepted; `o_ready = (state == IDLE)`.
- `i_md_op`  in  3  operation select, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_op_a`  in  XLEN  operand a (multiplicand or dividend).
- `i_op_b`  in  XLEN  operand b (multiplier or divisor).
- `i_kill`  in  1  synchronous abort of any in-flight or held operation.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts the result.
- `o_result`  out  XLEN  registered result.
- `o_div_zero`  out  1  the result came from a divide or remainder with `i_op_b == 0`.

## Operation
- **State machine.** States are IDLE, CALC, FIX and DONE.
  - IDLE → CALC: on accept (`i_valid & o_ready`) in the normal case.
  - IDLE → DONE: on accept in the fast-path case.
  - CALC → FIX: after XLEN iterations.
  - FIX → DONE: unconditionally.
  - DONE → IDLE: on `o_valid & i_ready`.
- **Accept.** Operands and op are latched. Signed operands (a for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM) are converted to magnitudes. The result sign is recorded.
- **Multiply.** Shift-add over unsigned magnitudes with a 2·XLEN product register.
  - FIX negates the product if the sign flag is set.
  - MUL returns `product[XLEN-1:0]`; all MULH* ops return `product[2XLEN-1:XLEN]`.
- **Divide.** Restoring division, one quotient bit per CALC cycle.
  - FIX negates the quotient if the operand signs differ.
  - FIX negates the remainder if the dividend is negative (remainder takes the dividend's sign).
- **Fast path.** The unit goes straight to DONE, with no CALC or FIX:
  - Divisor zero: quotient is all-ones, remainder equals `i_op_a`, and `o_div_zero` is 1.
  - DIV/REM with `a = 2^(XLEN-1)` and `b = all-ones`: quotient equals `a`, remainder is 0.
- **Kill.** `i_kill` in any state moves the unit to IDLE on the next edge and drops `o_valid`. It has priority over accept in the same cycle; a request presented with `i_kill` is not accepted.
- **Arithmetic.** All arithmetic is modulo 2^XLEN, or 2^(2XLEN) for the product; there are no exceptions.

## Timing
- **Reset values.** State is IDLE, so `o_ready` is 1. `o_valid`, `o_result` and `o_div_zero` are 0. Reset asserted mid-operation discards the operation immediately (asynchronously).
- **Normal latency.** Accept edge at cycle 0. CALC spans cycles 1..XLEN, FIX is cycle XLEN+1, and `o_valid` is first high in cycle XLEN+2 (cycle 34 for XLEN=32).
- **Fast-path latency.** `o_valid` is high in cycle 1.
- **Hold.** `o_result` and `o_div_zero` are stable while `o_valid` is high and `i_ready` is low. `o_ready` stays low until the handshake completes.
- **Back-to-back.** After the result handshake edge, `o_ready` is 1 in the next cycle. There is no overlap between operations.
- **Late inputs.** `i_md_op` and operand changes after accept have no effect.

## Configuration
- **`RV_MULDIV_DIV_EN` defined:** all eight ops are supported as above.
- **`RV_MULDIV_DIV_EN` undefined:**
  - The divider datapath is removed.
  - Ops 100–111 take the fast path with `o_result = 0` and `o_div_zero = 0`.
  - Multiply behaviour and latency are unchanged.

## Test plan
XLEN=32 throughout.
- **MUL.** MUL 7 × 0xFFFFFFFD → `o_result` 0xFFFFFFEB, `o_valid` first high 34 cycles after accept, `o_ready` low for that whole span.
- **High-half products.**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide.** DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 % 7 → 2.
- **Fast path.**
  - DIVU 5/0 → 0xFFFFFFFF with `o_div_zero` = 1, `o_valid` in cycle 1.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Backpressure and back-to-back.** Hold `i_ready` low for 5 cycles after `o_valid` rises → result and `o_valid` stable, `o_ready` low. After the handshake, the next request is accepted in the following cycle.
- **Kill and reset.**
  - `i_kill` at cycle 10 of a MUL → unit in IDLE next cycle, no `o_valid`.
  - `i_kill` with `i_valid` in IDLE → request not accepted.
  - `i_rst_n` low mid-CALC → all outputs at reset values immediately.

Source files
------------

// File: rtl/rv_muldiv.sv
// -----------------------------------------------------------------------------
// rv_muldiv -- iterative RV32M multiply/divide unit (one bit per clock).
//
// Accepts one operation over a valid/ready handshake and holds the result
// until the consumer takes it. Multiplication is shift-add over operand
// magnitudes with a 2*XLEN product register. Division is restoring, one
// quotient bit per cycle, sharing the same register. Signs are applied in
// a single FIX cycle. Divide-by-zero and signed overflow complete on a fast
// path straight to DONE.
//
// Configuration macro:
//   RV_MULDIV_DIV_EN  defined   -> divider present, all eight ops supported
//                     undefined -> divider removed; ops 1xx finish on the
//                                  fast path with result 0, div_zero 0
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     request valid
//   o_ready     unit idle, request can be accepted
//   i_md_op     RV32M funct3 (MUL..REMU)
//   i_op_a      operand a (multiplicand / dividend)
//   i_op_b      operand b (multiplier / divisor)
//   i_kill      synchronous abort of any in-flight or held operation
//   o_valid     result valid
//   i_ready     consumer accepts the result
//   o_result    registered result
//   o_div_zero  result came from a divide/remainder by zero
// -----------------------------------------------------------------------------
module rv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_div_zero
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;        // product / quotient sign
  logic [XLEN-1:0]     a_q, a_d;            // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   prod_q, prod_d;      // product, or {remainder, quotient}
  logic [XLEN-1:0]     result_q, result_d;
  logic                div_zero_q, div_zero_d;
`ifdef RV_MULDIV_DIV_EN
  logic                neg_rem_q, neg_rem_d; // remainder follows dividend sign
`endif

  logic                accept_s;
  logic                a_signed_s, b_signed_s;
  logic                a_neg_s, b_neg_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic                fast_s;
  logic [XLEN-1:0]     fast_result_s;
  logic                fast_div_zero_s;
  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   prod_fix_s;
`ifdef RV_MULDIV_DIV_EN
  logic [2*XLEN:0]     div_shift_s;
  logic [XLEN:0]       div_trial_s;
  logic [XLEN-1:0]     quo_fix_s;
  logic [XLEN-1:0]     rem_fix_s;
  logic                div_by_zero_s;
  logic                div_ovf_s;
`endif

  assign o_ready    = (state_q == S_IDLE);
  assign o_valid    = (state_q == S_DONE);
  assign o_result   = result_q;
  assign o_div_zero = div_zero_q;

  // Kill blocks acceptance in the same cycle.
  assign accept_s = i_valid & (state_q == S_IDLE) & ~i_kill;

  // Operand sign handling at accept.
  assign a_signed_s = (i_md_op == OP_MULH) | (i_md_op == OP_MULHSU) |
                      (i_md_op == OP_DIV)  | (i_md_op == OP_REM);
  assign b_signed_s = (i_md_op == OP_MULH) | (i_md_op == OP_DIV) |
                      (i_md_op == OP_REM);
  assign a_neg_s    = a_signed_s & i_op_a[XLEN-1];
  assign b_neg_s    = b_signed_s & i_op_b[XLEN-1];
  assign a_mag_s    = a_neg_s ? (-i_op_a) : i_op_a;
  assign b_mag_s    = b_neg_s ? (-i_op_b) : i_op_b;

`ifdef RV_MULDIV_DIV_EN
  assign div_by_zero_s = i_md_op[2] & (i_op_b == {XLEN{1'b0}});
  // Most-negative dividend over -1 overflows; answer is fixed.
  assign div_ovf_s     = ((i_md_op == OP_DIV) | (i_md_op == OP_REM)) &
                         (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) &
                         (i_op_b == {XLEN{1'b1}});
  assign fast_s          = div_by_zero_s | div_ovf_s;
  assign fast_div_zero_s = div_by_zero_s;
  // op[1] selects the remainder variants (REM/REMU).
  assign fast_result_s   = div_by_zero_s ? (i_md_op[1] ? i_op_a : {XLEN{1'b1}})
                                         : (i_md_op[1] ? {XLEN{1'b0}} : i_op_a);
`else
  assign fast_s          = i_md_op[2];
  assign fast_div_zero_s = 1'b0;
  assign fast_result_s   = {XLEN{1'b0}};
`endif

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit (product LSB) is set, then shift right by one.
  assign mul_sum_s = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                     (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});

  assign prod_fix_s = neg_q ? (-prod_q) : prod_q;

`ifdef RV_MULDIV_DIV_EN
  // Restoring step: shift {rem, quo} left, try subtracting the divisor.
  assign div_shift_s = {prod_q, 1'b0};
  assign div_trial_s = div_shift_s[2*XLEN:XLEN] - {1'b0, a_q};
  assign quo_fix_s   = neg_q ? (-prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
  assign rem_fix_s   = neg_rem_q ? (-prod_q[2*XLEN-1:XLEN]) : prod_q[2*XLEN-1:XLEN];
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; kill overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = fast_s ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: state_d = S_DONE;
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_kill) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Datapath next-state: latch at accept, iterate in CALC, sign-fix in FIX.
  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    a_d        = a_q;
    prod_d     = prod_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
`ifdef RV_MULDIV_DIV_EN
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = i_md_op;
          cnt_d = {CW{1'b0}};
          neg_d = a_neg_s ^ b_neg_s;
`ifdef RV_MULDIV_DIV_EN
          neg_rem_d = a_neg_s;
`endif
          if (i_md_op[2]) begin
            a_d    = b_mag_s;
            prod_d = {{XLEN{1'b0}}, a_mag_s};
          end else begin
            a_d    = a_mag_s;
            prod_d = {{XLEN{1'b0}}, b_mag_s};
          end
          if (fast_s) begin
            result_d   = fast_result_s;
            div_zero_d = fast_div_zero_s;
          end else begin
            div_zero_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
`ifdef RV_MULDIV_DIV_EN
        if (op_q[2]) begin
          if (!div_trial_s[XLEN]) begin
            prod_d = {div_trial_s[XLEN-1:0], div_shift_s[XLEN-1:1], 1'b1};
          end else begin
            prod_d = div_shift_s[2*XLEN-1:0];
          end
        end else begin
          prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
        end
`else
        prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
`endif
      end
      S_FIX: begin
`ifdef RV_MULDIV_DIV_EN
        if (op_q[2]) begin
          result_d = op_q[1] ? rem_fix_s : quo_fix_s;
        end else if (op_q == OP_MUL) begin
          result_d = prod_fix_s[XLEN-1:0];
        end else begin
          result_d = prod_fix_s[2*XLEN-1:XLEN];
        end
`else
        if (op_q == OP_MUL) begin
          result_d = prod_fix_s[XLEN-1:0];
        end else begin
          result_d = prod_fix_s[2*XLEN-1:XLEN];
        end
`endif
      end
      S_DONE: begin
        result_d = result_q;
      end
      default: begin
        result_d = result_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= {CW{1'b0}};
      op_q       <= 3'b000;
      neg_q      <= 1'b0;
      a_q        <= {XLEN{1'b0}};
      prod_q     <= {(2*XLEN){1'b0}};
      result_q   <= {XLEN{1'b0}};
      div_zero_q <= 1'b0;
`ifdef RV_MULDIV_DIV_EN
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      a_q        <= a_d;
      prod_q     <= prod_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
`ifdef RV_MULDIV_DIV_EN
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

endmodule
